synapse_accumulator: RTL and testbench

- Collects weighted spike events for one timestep into two synaptic-current channels.
- At each timestep boundary, drives a one-cycle load to the current-decay stage.
- Sits upstream of the decay stage: its write and current outputs connect to that stage's write and curr_in1/curr_in2 inputs.
- Spike events arrive over a valid/ready handshake; the timestep boundary arrives as a single-cycle strobe.

---
 rtl/izh_pkg.sv | 23 ++
 rtl/synacc_add.sv | 34 +++
 rtl/synapse_accumulator.sv | 130 +++++++++++++
 tb/tb_synapse_accumulator.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/izh_pkg.sv
// Shared definitions for the spiking-neuron datapath: default word width,
// accumulator FSM states and signed saturation limits.
package izh_pkg;

    localparam int IZH_WIDTH = 16;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_FLUSH = 1'b1
    } synacc_state_t;

    function automatic logic signed [63:0] izh_sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] izh_sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    localparam logic signed [IZH_WIDTH-1:0] IZH_SAT_MAX = IZH_WIDTH'(izh_sat_max(IZH_WIDTH));
    localparam logic signed [IZH_WIDTH-1:0] IZH_SAT_MIN = IZH_WIDTH'(izh_sat_min(IZH_WIDTH));

endpackage

// File: rtl/synacc_add.sv
// Signed WIDTH-bit adder with overflow flag; clamps to the signed range when
// SYNACC_SATURATE_EN is defined, otherwise wraps modulo 2^WIDTH.
module synacc_add
    import izh_pkg::*;
#(
    parameter int WIDTH = IZH_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_ovf
);

    logic signed [WIDTH-1:0] w_a;
    logic signed [WIDTH-1:0] w_b;
    logic signed [WIDTH-1:0] w_raw;

    assign w_a   = i_a;
    assign w_b   = i_b;
    assign w_raw = w_a + w_b;

    // Overflow only when both operands share a sign the raw sum does not.
    assign o_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_raw[WIDTH-1] != w_a[WIDTH-1]);

`ifdef SYNACC_SATURATE_EN
    localparam logic signed [WIDTH-1:0] L_MAX = WIDTH'(izh_sat_max(WIDTH));
    localparam logic signed [WIDTH-1:0] L_MIN = WIDTH'(izh_sat_min(WIDTH));

    assign o_sum = !o_ovf ? w_raw : (w_a[WIDTH-1] ? L_MIN : L_MAX);
`else
    assign o_sum = w_raw;
`endif

endmodule

// File: rtl/synapse_accumulator.sv
// Accumulates weighted spikes per timestep into two current channels and
// flushes them to the decay stage with a one-cycle write. Option: SYNACC_SATURATE_EN.
module synapse_accumulator
    import izh_pkg::*;
#(
    parameter int WIDTH = IZH_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spike_valid,
    output logic             spike_ready,
    input  logic             spike_chan,
    input  logic [WIDTH-1:0] spike_weight,
    input  logic             step,
    output logic             write,
    output logic [WIDTH-1:0] curr_out1,
    output logic [WIDTH-1:0] curr_out2,
    output logic [CNT_W-1:0] spike_cnt,
    output logic             ovf
);

    synacc_state_t r_state;
    synacc_state_t w_next_state;

    logic signed [WIDTH-1:0] r_acc1;
    logic signed [WIDTH-1:0] r_acc2;
    logic signed [WIDTH-1:0] r_curr1;
    logic signed [WIDTH-1:0] r_curr2;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        r_spike_cnt;
    logic                    r_pending;
    logic                    r_ovf;

    logic                    w_ready;
    logic                    w_write;
    logic                    w_accept;
    logic                    w_flush;
    logic [WIDTH-1:0]        w_sum1;
    logic [WIDTH-1:0]        w_sum2;
    logic                    w_ovf1;
    logic                    w_ovf2;
    logic signed [WIDTH-1:0] w_acc1_nxt;
    logic signed [WIDTH-1:0] w_acc2_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_add_ovf;

    synacc_add #(.WIDTH(WIDTH)) u_add1 (
        .i_a   (r_acc1),
        .i_b   (spike_weight),
        .o_sum (w_sum1),
        .o_ovf (w_ovf1)
    );

    synacc_add #(.WIDTH(WIDTH)) u_add2 (
        .i_a   (r_acc2),
        .i_b   (spike_weight),
        .o_sum (w_sum2),
        .o_ovf (w_ovf2)
    );

    assign w_accept   = spike_valid && w_ready;
    assign w_flush    = (r_state == ST_ACCUM) && (step || r_pending);
    assign w_acc1_nxt = (w_accept && !spike_chan) ? w_sum1 : r_acc1;
    assign w_acc2_nxt = (w_accept &&  spike_chan) ? w_sum2 : r_acc2;
    assign w_cnt_nxt  = (w_accept && (r_cnt != {CNT_W{1'b1}})) ? r_cnt + 1'b1 : r_cnt;
    assign w_add_ovf  = w_accept && (spike_chan ? w_ovf2 : w_ovf1);

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                // Reset holds the state in ACCUM, so ready must be masked explicitly.
                w_ready = !rst;
                if (w_flush) begin
                    w_next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_write      = 1'b1;
                w_next_state = ST_ACCUM;
            end
            default: w_next_state = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_acc1      <= '0;
            r_acc2      <= '0;
            r_cnt       <= '0;
            r_curr1     <= '0;
            r_curr2     <= '0;
            r_spike_cnt <= '0;
            r_pending   <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ovf   <= r_ovf | w_add_ovf;
            if (w_flush) begin
                r_curr1     <= w_acc1_nxt;
                r_curr2     <= w_acc2_nxt;
                r_spike_cnt <= w_cnt_nxt;
                r_acc1      <= '0;
                r_acc2      <= '0;
                r_cnt       <= '0;
                r_pending   <= 1'b0;
            end else begin
                r_acc1 <= w_acc1_nxt;
                r_acc2 <= w_acc2_nxt;
                r_cnt  <= w_cnt_nxt;
            end
            // A step landing on the flush cycle is deferred to the next ACCUM cycle.
            if ((r_state == ST_FLUSH) && step) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign spike_ready = w_ready;
    assign write       = w_write;
    assign curr_out1   = r_curr1;
    assign curr_out2   = r_curr2;
    assign spike_cnt   = r_spike_cnt;
    assign ovf         = r_ovf;

endmodule

// File: tb/tb_synapse_accumulator.sv
// Directed self-checking bench for synapse_accumulator (honours SYNACC_SATURATE_EN).
module tb_synapse_accumulator;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             spike_valid;
    logic             spike_ready;
    logic             spike_chan;
    logic [WIDTH-1:0] spike_weight;
    logic             step;
    logic             write;
    logic [WIDTH-1:0] curr_out1;
    logic [WIDTH-1:0] curr_out2;
    logic [CNT_W-1:0] spike_cnt;
    logic             ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc    = 0;
    int n_acc0   = 0;

    synapse_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .spike_valid  (spike_valid),
        .spike_ready  (spike_ready),
        .spike_chan   (spike_chan),
        .spike_weight (spike_weight),
        .step         (step),
        .write        (write),
        .curr_out1    (curr_out1),
        .curr_out2    (curr_out2),
        .spike_cnt    (spike_cnt),
        .ovf          (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && spike_valid && spike_ready) n_acc <= n_acc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spike(input logic ch, input logic [WIDTH-1:0] w);
        spike_valid  = 1'b1;
        spike_chan   = ch;
        spike_weight = w;
        tick();
        spike_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b0; spike_valid = 1'b0; spike_chan = 1'b0; spike_weight = '0; step = 1'b0;
        #1 rst = 1'b1;
        tick(); tick();
        chk("rst_ready", spike_ready, 0);
        chk("rst_write", write, 0);
        chk("rst_curr1", curr_out1, 0);
        chk("rst_cnt",   spike_cnt, 0);
        chk("rst_ovf",   ovf, 0);
        rst = 1'b0;
        tick();
        chk("idle_ready", spike_ready, 1);
        chk("idle_write", write, 0);

        // Basic accumulation across both channels
        spike(1'b0, 16'd100);
        spike(1'b0, 16'd200);
        spike(1'b0, 16'd300);
        spike(1'b1, 16'hFFCE);
        step = 1'b1; tick(); step = 1'b0;
        chk("t1_write", write, 1);
        chk("t1_ready", spike_ready, 0);
        chk("t1_curr1", curr_out1, 600);
        chk("t1_curr2", curr_out2, 16'hFFCE);
        chk("t1_cnt",   spike_cnt, 4);
        tick();
        chk("t1_write_drop", write, 0);
        chk("t1_ready_back", spike_ready, 1);

        // Spike coincident with step is included in that flush
        spike_valid = 1'b1; spike_chan = 1'b1; spike_weight = 16'd7; step = 1'b1;
        tick();
        spike_valid = 1'b0; step = 1'b0;
        chk("t2_curr1", curr_out1, 0);
        chk("t2_curr2", curr_out2, 7);
        chk("t2_cnt",   spike_cnt, 1);
        tick();
        step = 1'b1; tick(); step = 1'b0;
        chk("t2_empty_curr2", curr_out2, 0);
        chk("t2_empty_cnt",   spike_cnt, 0);
        chk("t2_ovf_clear",   ovf, 0);
        tick();

        // Overflow: 0x7000 + 0x7000
        spike(1'b0, 16'h7000);
        spike(1'b0, 16'h7000);
        step = 1'b1; tick(); step = 1'b0;
`ifdef SYNACC_SATURATE_EN
        chk("t3_curr1", curr_out1, 16'h7FFF);
`else
        chk("t3_curr1", curr_out1, 16'hE000);
`endif
        chk("t3_ovf", ovf, 1);
        tick();

        // step held two cycles with one spike in the intervening ACCUM cycle
        step = 1'b1; tick();
        chk("t4_write_n1", write, 1);
        chk("t4_ready_n1", spike_ready, 0);
        tick(); step = 1'b0;
        chk("t4_write_n2", write, 0);
        chk("t4_ready_n2", spike_ready, 1);
        spike(1'b0, 16'd5);
        chk("t4_write_n3", write, 1);
        chk("t4_curr1", curr_out1, 5);
        chk("t4_curr2", curr_out2, 0);
        chk("t4_cnt",   spike_cnt, 1);
        tick();
        chk("t4_write_n4", write, 0);
        // Same again with no spike between the flushes
        step = 1'b1; tick(); tick(); step = 1'b0;
        chk("t4z_write_n2", write, 0);
        tick();
        chk("t4z_write_n3", write, 1);
        chk("t4z_curr1", curr_out1, 0);
        chk("t4z_cnt",   spike_cnt, 0);
        tick();

        // spike_valid held across a flush
        n_acc0 = n_acc;
        spike_valid = 1'b1; spike_chan = 1'b1; spike_weight = 16'd1;
        tick(); tick(); tick();
        step = 1'b1; tick(); step = 1'b0;
        chk("t5_ready_flush", spike_ready, 0);
        chk("t5_curr2_a", curr_out2, 4);
        chk("t5_cnt_a",   spike_cnt, 4);
        tick(); tick(); tick();
        step = 1'b1; tick(); step = 1'b0;
        spike_valid = 1'b0;
        chk("t5_curr2_b", curr_out2, 3);
        chk("t5_cnt_b",   spike_cnt, 3);
        chk("t5_vr_cycles", n_acc - n_acc0, 7);
        tick();

        // Reset asserted during FLUSH
        spike(1'b0, 16'd9);
        step = 1'b1; tick(); step = 1'b0;
        chk("t6_write_pre", write, 1);
        chk("t6_curr1_pre", curr_out1, 9);
        #1 rst = 1'b1;
        #1;
        chk("t6_write", write, 0);
        chk("t6_ready", spike_ready, 0);
        chk("t6_curr1", curr_out1, 0);
        chk("t6_curr2", curr_out2, 0);
        chk("t6_cnt",   spike_cnt, 0);
        chk("t6_ovf",   ovf, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_rel_ready", spike_ready, 1);
        chk("t6_rel_write", write, 0);
        spike_valid = 1'b1; spike_chan = 1'b0; spike_weight = 16'd3; step = 1'b1;
        tick();
        spike_valid = 1'b0; step = 1'b0;
        chk("t6_post_curr1", curr_out1, 3);
        chk("t6_post_curr2", curr_out2, 0);
        chk("t6_post_cnt",   spike_cnt, 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
